// File: rtl/serial_neg_pkg.sv
// Shared definitions for the bit-serial negate scheduler: FSM encoding and default word width.
package serial_neg_pkg;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;
endpackage

// File: rtl/serial_neg_cell.sv
// Bit-serial two's-complement cell: copies bits up to and including the first 1, inverts the rest.
// One bit per clock, no backpressure; 'first' marks the LSB and clears the history combinationally.
module serial_neg_cell (
  input  logic clk,
  input  logic reset_n,
  input  logic bit_in,
  input  logic neg,
  input  logic first,
  output logic bit_out
);
  logic r_seen_one;
  logic w_seen_one;

  assign w_seen_one = first ? 1'b0 : r_seen_one;
  assign bit_out    = (neg && w_seen_one) ? ~bit_in : bit_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_seen_one <= 1'b0;
    else          r_seen_one <= w_seen_one | bit_in;
  end
endmodule

// File: rtl/serial_neg_scheduler.sv
// Round-robin shares one serial negate cell between two word requesters; result valid WIDTH clocks
// after accept, held in DONE until res_ready; no new accept while busy (issue interval WIDTH+2).
module serial_neg_scheduler
  import serial_neg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_neg,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_neg,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  input  logic             res_ready,
  output logic             ser_bit,
  output logic             ser_first,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_id;
  logic             r_last_grant;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic             w_shift;
  logic             w_first;
  logic             w_last_bit;
  logic             w_cell_out;

  // On a tie the requester that did not win last time is granted.
  assign w_grant0   = req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1   = req1_valid && !w_grant0;
  assign w_shift    = (r_state == S_SHIFT);
  assign w_first    = (r_cnt == '0);
  assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

  serial_neg_cell u_cell (
    .clk     (clk),
    .reset_n (reset_n),
    .bit_in  (w_shift & r_sh[0]),
    .neg     (r_neg),
    .first   (w_first),
    .bit_out (w_cell_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    res_valid  = 1'b0;
    ser_bit    = 1'b0;
    ser_first  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
        w_accept   = w_grant0 | w_grant1;
        if (w_accept) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        ser_bit   = w_cell_out;
        ser_first = w_first;
        if (w_last_bit) w_next = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy     = (r_state != S_IDLE);
  assign res_data = r_res;
  assign res_id   = r_id;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh         <= '0;
      r_res        <= '0;
      r_cnt        <= '0;
      r_neg        <= 1'b0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_sh         <= w_grant1 ? req1_data : req0_data;
      r_neg        <= w_grant1 ? req1_neg : req0_neg;
      r_id         <= w_grant1;
      r_last_grant <= w_grant1;
      r_cnt        <= '0;
    end else if (w_shift) begin
      // Result fills from the MSB end so the LSB-first stream lands in place after WIDTH shifts.
      r_res <= {w_cell_out, r_res[WIDTH-1:1]};
      r_sh  <= r_sh >> 1;
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_neg_scheduler.sv
// Bench for serial_neg_scheduler: directed cases plus random traffic against a word-level reference model.
module tb_serial_neg_scheduler;
  localparam int W = 4;

  typedef struct {
    logic         id;
    logic [W-1:0] res;
  } done_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         vld [2];
  logic         ng [2];
  logic [W-1:0] dat [2];
  logic         res_ready;
  logic         req0_ready, req1_ready, res_valid, res_id, ser_bit, ser_first, busy;
  logic [W-1:0] res_data;

  int    checks = 0;
  int    failures = 0;
  bit    acc [2];
  bit    pend = 0;
  int    k = 0;
  logic  model_last = 1'b1;
  logic  exp_id = 1'b0;
  logic [W-1:0] exp_res = '0;
  int    acc_cnt = 0;
  int    done_cnt = 0;
  int    aborted = 0;
  done_t done_q [$];

  always #5 clk = ~clk;

  serial_neg_scheduler #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (vld[0]),
    .req0_data  (dat[0]),
    .req0_neg   (ng[0]),
    .req0_ready (req0_ready),
    .req1_valid (vld[1]),
    .req1_data  (dat[1]),
    .req1_neg   (ng[1]),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .ser_bit    (ser_bit),
    .ser_first  (ser_first),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Two's complement as 2^W - x, reduced mod 2^W.
  function automatic logic [W-1:0] neg_model(input logic [W-1:0] x, input logic n);
    int unsigned v;
    v = n ? (((1 << W) - int'(x)) % (1 << W)) : int'(x);
    return v[W-1:0];
  endfunction

  // Cycle-level observer: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic g0, g1;
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    if (!reset_n) begin
      check_eq("rst_busy", busy, 0);
      check_eq("rst_res_valid", res_valid, 0);
      check_eq("rst_ser_bit", ser_bit, 0);
      check_eq("rst_ser_first", ser_first, 0);
      check_eq("rst_rdy0", req0_ready, 0);
      check_eq("rst_rdy1", req1_ready, 0);
      check_eq("rst_res_data", res_data, 0);
      check_eq("rst_res_id", res_id, 0);
      if (pend) aborted++;
      pend = 0;
      model_last = 1'b1;
    end else if (pend) begin
      k++;
      check_eq("busy_active", busy, 1);
      check_eq("rdy0_while_busy", req0_ready, 0);
      check_eq("rdy1_while_busy", req1_ready, 0);
      if (k <= W) begin
        check_eq("ser_bit", ser_bit, exp_res[k-1]);
        check_eq("ser_first", ser_first, k == 1);
        check_eq("early_res_valid", res_valid, 0);
      end else begin
        check_eq("res_valid", res_valid, 1);
        check_eq("res_data", res_data, exp_res);
        check_eq("res_id", res_id, exp_id);
        check_eq("ser_bit_done", ser_bit, 0);
        check_eq("ser_first_done", ser_first, 0);
        if (res_ready) begin
          pend = 0;
          done_q.push_back('{exp_id, exp_res});
          done_cnt++;
        end
      end
    end else begin
      check_eq("busy_idle", busy, 0);
      check_eq("res_valid_idle", res_valid, 0);
      check_eq("ser_bit_idle", ser_bit, 0);
      check_eq("ser_first_idle", ser_first, 0);
      g0 = vld[0] && (!vld[1] || model_last);
      g1 = vld[1] && !g0;
      check_eq("grant0", req0_ready, g0);
      check_eq("grant1", req1_ready, g1);
      if (g0 || g1) begin
        pend = 1;
        k = 0;
        exp_id = g1;
        exp_res = g1 ? neg_model(dat[1], ng[1]) : neg_model(dat[0], ng[0]);
        model_last = g1;
        acc[0] = g0;
        acc[1] = g1;
        acc_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) if (acc[r]) vld[r] = 1'b0;
  endtask

  task automatic send(input int id, input logic [W-1:0] d, input logic n);
    vld[id] = 1'b1;
    dat[id] = d;
    ng[id]  = n;
    for (int i = 0; i < 100 && vld[id]; i++) tick();
    if (vld[id]) begin
      check_eq("send_timeout", vld[id], 0);
      vld[id] = 1'b0;
    end
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 400; i++) begin
      if (!vld[0] && !vld[1] && !pend) break;
      tick();
    end
    if (i == 400) check_eq("drain_timeout", pend, 0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] bvals [4];
    logic [W-1:0] bexp [4];
    int start;
    int i;
    vld[0] = 1'b0; vld[1] = 1'b0;
    ng[0]  = 1'b0; ng[1]  = 1'b0;
    dat[0] = '0;   dat[1] = '0;
    acc[0] = 1'b0; acc[1] = 1'b0;
    res_ready = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    send(0, 4'b0110, 1'b1);
    drain();
    check_eq("neg_0110_data", done_q[$].res, 4'b1010);
    check_eq("neg_0110_id", done_q[$].id, 0);

    send(1, 4'b0101, 1'b0);
    drain();
    check_eq("pass_0101_data", done_q[$].res, 4'b0101);
    check_eq("pass_0101_id", done_q[$].id, 1);

    pulse_reset();
    done_q.delete();
    vld[0] = 1'b1; dat[0] = 4'b0011; ng[0] = 1'b1;
    vld[1] = 1'b1; dat[1] = 4'b0001; ng[1] = 1'b1;
    drain();
    check_eq("tie_count", done_q.size(), 2);
    if (done_q.size() == 2) begin
      check_eq("tie_first_id", done_q[0].id, 0);
      check_eq("tie_first_data", done_q[0].res, 4'b1101);
      check_eq("tie_second_id", done_q[1].id, 1);
      check_eq("tie_second_data", done_q[1].res, 4'b1111);
    end

    done_q.delete();
    start = acc_cnt;
    for (i = 0; i < 400; i++) begin
      tick();
      for (int r = 0; r < 2; r++)
        if (!vld[r] && (acc_cnt - start) < 6) begin
          vld[r] = 1'b1; dat[r] = W'($urandom); ng[r] = 1'b1;
        end
      if (!vld[0] && !vld[1] && !pend) break;
    end
    drain();
    check_eq("alt_enough", done_q.size() >= 6, 1);
    if (done_q.size() >= 6)
      for (int j = 0; j < 6; j++) check_eq("alt_id", done_q[j].id, j % 2);

    res_ready = 1'b0;
    send(0, 4'b0101, 1'b1);
    vld[1] = 1'b1; dat[1] = 4'b0011; ng[1] = 1'b0;
    for (i = 0; i < 20 && !res_valid; i++) tick();
    check_eq("bp_valid_rise", res_valid, 1);
    for (int j = 0; j < 5; j++) begin
      tick();
      check_eq("bp_valid_hold", res_valid, 1);
      check_eq("bp_data_hold", res_data, 4'b1011);
      check_eq("bp_id_hold", res_id, 0);
      check_eq("bp_rdy0", req0_ready, 0);
      check_eq("bp_rdy1", req1_ready, 0);
      check_eq("bp_busy", busy, 1);
    end
    res_ready = 1'b1;
    tick();
    check_eq("bp_release_valid", res_valid, 0);
    check_eq("bp_release_busy", busy, 0);
    check_eq("bp_release_data", done_q[$].res, 4'b1011);
    drain();
    check_eq("bp_waiter_data", done_q[$].res, 4'b0011);
    check_eq("bp_waiter_id", done_q[$].id, 1);

    bvals[0] = 4'b0000; bexp[0] = 4'b0000;
    bvals[1] = 4'b1000; bexp[1] = 4'b1000;
    bvals[2] = 4'b1111; bexp[2] = 4'b0001;
    bvals[3] = 4'b0001; bexp[3] = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      send(j % 2, bvals[j], 1'b1);
      drain();
      check_eq("boundary_neg", done_q[$].res, bexp[j]);
    end

    start = done_cnt;
    send(1, 4'b1011, 1'b1);
    tick();
    tick();
    #1 reset_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ser_bit", ser_bit, 0);
    check_eq("abort_res_valid", res_valid, 0);
    check_eq("abort_res_data", res_data, 0);
    tick();
    tick();
    check_eq("abort_no_result", done_cnt - start, 0);
    check_eq("abort_counted", aborted, 1);
    reset_n = 1'b1;
    done_q.delete();
    vld[0] = 1'b1; dat[0] = 4'b0010; ng[0] = 1'b1;
    vld[1] = 1'b1; dat[1] = 4'b0111; ng[1] = 1'b0;
    drain();
    check_eq("post_reset_count", done_q.size(), 2);
    if (done_q.size() == 2) begin
      check_eq("post_reset_id", done_q[0].id, 0);
      check_eq("post_reset_data", done_q[0].res, 4'b1110);
      check_eq("post_reset_second", done_q[1].res, 4'b0111);
    end

    for (int c = 0; c < 2000; c++) begin
      tick();
      res_ready = ($urandom_range(3) != 0);
      for (int r = 0; r < 2; r++)
        if (!vld[r] && $urandom_range(2) == 0) begin
          vld[r] = 1'b1; dat[r] = W'($urandom); ng[r] = 1'($urandom_range(1));
        end
    end
    res_ready = 1'b1;
    drain();
    check_eq("accept_vs_complete", done_cnt + aborted, acc_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
